// File: rtl/lut_loader.sv
// Run-time loader for the activation lookup tables: accepts a serial word stream
// and writes it into a two-port BRAM as even/odd address pairs, one pair per write cycle.
module lut_loader #(
    parameter int LUT_ADDR_SIZE = 10,
    parameter int LUT_DEPTH     = 1 << LUT_ADDR_SIZE,
    parameter int LUT_WIDTH     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LUT_WIDTH-1:0]     data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic                     writeEnable0,
    output logic [LUT_ADDR_SIZE-1:0] writeAddress0,
    output logic [LUT_WIDTH-1:0]     writeData0,
    output logic                     writeEnable1,
    output logic [LUT_ADDR_SIZE-1:0] writeAddress1,
    output logic [LUT_WIDTH-1:0]     writeData1,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [LUT_ADDR_SIZE:0]   LAST_WORD = (LUT_ADDR_SIZE+1)'(LUT_DEPTH - 1);
    localparam logic [LUT_ADDR_SIZE:0]   COUNT_ONE = (LUT_ADDR_SIZE+1)'(1);
    localparam logic [LUT_ADDR_SIZE-1:0] ADDR_LSB  = LUT_ADDR_SIZE'(1);

    state_t                 state;
    state_t                 next_state;
    logic [LUT_ADDR_SIZE:0] word_count;
    logic [LUT_WIDTH-1:0]   hold;
    logic                   accept;

    always_comb begin
        next_state    = state;
        data_in_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                data_in_ready = 1'b1;
                busy          = 1'b1;
                accept        = data_in_valid;
                if (data_in_valid && (word_count == LAST_WORD)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Even words wait in the hold register; the odd word completes the pair and
    // both ports are written together on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            word_count    <= '0;
            hold          <= '0;
            writeEnable0  <= 1'b0;
            writeEnable1  <= 1'b0;
            writeAddress0 <= '0;
            writeAddress1 <= '0;
            writeData0    <= '0;
            writeData1    <= '0;
        end else begin
            state        <= next_state;
            writeEnable0 <= 1'b0;
            writeEnable1 <= 1'b0;
            if ((state == IDLE) && start) begin
                word_count <= '0;
            end
            if (accept) begin
                word_count <= word_count + COUNT_ONE;
                if (!word_count[0]) begin
                    hold <= data_in;
                end else begin
                    writeEnable0  <= 1'b1;
                    writeEnable1  <= 1'b1;
                    writeAddress0 <= word_count[LUT_ADDR_SIZE-1:0] & ~ADDR_LSB;
                    writeAddress1 <= word_count[LUT_ADDR_SIZE-1:0];
                    writeData0    <= hold;
                    writeData1    <= data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_loader.sv
// Randomized self-checking bench for lut_loader: a small (depth 8) and a default
// (depth 1024) instance share stimulus; 'sel' picks which one is checked.
module tb_lut_loader;

    localparam int W  = 9;
    localparam int SA = 3;
    localparam int SD = 8;
    localparam int BA = 10;
    localparam int BD = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         data_in_valid;
    logic [W-1:0] data_in;
    logic         sel;

    logic          sReady, sWe0, sWe1, sBusy, sDone;
    logic [SA-1:0] sA0, sA1;
    logic [W-1:0]  sD0, sD1;
    logic          bReady, bWe0, bWe1, bBusy, bDone;
    logic [BA-1:0] bA0, bA1;
    logic [W-1:0]  bD0, bD1;

    int checkCount = 0;
    int passCount  = 0;

    int mPhase, mCount, mHold, eWe, eA0, eA1, eD0, eD1;
    int wrCount [BD];
    int wrData  [BD];
    logic [W-1:0] sessWords [BD];
    int pairs, dones;

    always #5 clk = ~clk;

    lut_loader #(.LUT_ADDR_SIZE(SA), .LUT_DEPTH(SD), .LUT_WIDTH(W)) dutSmall (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_in_ready(sReady),
        .writeEnable0(sWe0), .writeAddress0(sA0), .writeData0(sD0),
        .writeEnable1(sWe1), .writeAddress1(sA1), .writeData1(sD1),
        .busy(sBusy), .done(sDone)
    );

    lut_loader dutBig (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_in_ready(bReady),
        .writeEnable0(bWe0), .writeAddress0(bA0), .writeData0(bD0),
        .writeEnable1(bWe1), .writeAddress1(bA1), .writeData1(bD1),
        .busy(bBusy), .done(bDone)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    endtask

    // Session-level behaviour: phase 0=idle, 1=loading, 2=finished.
    task automatic modelEdge(input logic r, input logic s, input logic v, input logic [W-1:0] d);
        int depth;
        depth = sel ? BD : SD;
        eWe = 0;
        if (r) begin
            mPhase = 0; mCount = 0; mHold = 0;
            eA0 = 0; eA1 = 0; eD0 = 0; eD1 = 0;
        end else if (mPhase == 0) begin
            if (s) begin mPhase = 1; mCount = 0; end
        end else if (mPhase == 1) begin
            if (v) begin
                if (mCount % 2 == 0) mHold = int'(d);
                else begin
                    eWe = 1; eA0 = mCount - 1; eA1 = mCount; eD0 = mHold; eD1 = int'(d);
                end
                if (mCount == depth - 1) mPhase = 2;
                mCount++;
            end
        end else begin
            mPhase = 0;
        end
    endtask

    task automatic sampleOutputs();
        int oReady, oWe0, oWe1, oBusy, oDone, oA0, oA1, oD0, oD1;
        oReady = int'(sel ? bReady : sReady);
        oWe0   = int'(sel ? bWe0 : sWe0);
        oWe1   = int'(sel ? bWe1 : sWe1);
        oBusy  = int'(sel ? bBusy : sBusy);
        oDone  = int'(sel ? bDone : sDone);
        oA0    = sel ? int'(bA0) : int'(sA0);
        oA1    = sel ? int'(bA1) : int'(sA1);
        oD0    = int'(sel ? bD0 : sD0);
        oD1    = int'(sel ? bD1 : sD1);
        checkOutput("ready", oReady, (mPhase == 1) ? 1 : 0);
        checkOutput("busy", oBusy, (mPhase != 0) ? 1 : 0);
        checkOutput("done", oDone, (mPhase == 2) ? 1 : 0);
        checkOutput("we0", oWe0, eWe);
        checkOutput("we1", oWe1, eWe);
        checkOutput("addr0", oA0, eA0);
        checkOutput("addr1", oA1, eA1);
        checkOutput("data0", oD0, eD0);
        checkOutput("data1", oD1, eD1);
        if (oWe0 == 1) begin wrCount[oA0]++; wrData[oA0] = oD0; pairs++; end
        if (oWe1 == 1) begin wrCount[oA1]++; wrData[oA1] = oD1; end
        if (oDone == 1) dones++;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [W-1:0] d);
        rst = r; start = s; data_in_valid = v; data_in = d;
        @(posedge clk);
        modelEdge(r, s, v, d);
        @(negedge clk);
        sampleOutputs();
    endtask

    task automatic clearBoard();
        for (int a = 0; a < BD; a++) begin wrCount[a] = 0; wrData[a] = -1; end
        pairs = 0; dones = 0;
    endtask

    task automatic feedWords(input int n, input int gapPercent);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gapPercent)
                applyStimulus(1'b0, 1'b0, 1'b0, W'($urandom_range(511)));
            applyStimulus(1'b0, 1'b0, 1'b1, sessWords[i]);
        end
    endtask

    task automatic checkSession(input int depth);
        for (int a = 0; a < depth; a++) begin
            checkOutput($sformatf("writes@%0d", a), wrCount[a], 1);
            checkOutput($sformatf("word@%0d", a), wrData[a], int'(sessWords[a]));
        end
        checkOutput("pairs", pairs, depth / 2);
        checkOutput("dones", dones, 1);
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1; start = 1'b0; data_in_valid = 1'b0; data_in = '0;
        mPhase = 0; mCount = 0; mHold = 0; eWe = 0; eA0 = 0; eA1 = 0; eD0 = 0; eD1 = 0;
        clearBoard();
        @(negedge clk);

        $display("[TB] reset and idle valid");
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, W'(9'h055));
        checkOutput("idlePairs", pairs, 0);

        $display("[TB] continuous stream");
        clearBoard();
        for (int i = 0; i < SD; i++) sessWords[i] = W'(16 + i);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        feedWords(SD, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkSession(SD);

        $display("[TB] valid gap after word 2");
        clearBoard();
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < SD; i++) begin
            if (i == 3)
                for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, 1'b0, W'(9'h1FF));
            applyStimulus(1'b0, 1'b0, 1'b1, sessWords[i]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkSession(SD);

        $display("[TB] start while busy");
        clearBoard();
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < SD; i++) applyStimulus(1'b0, (i == 4), 1'b1, sessWords[i]);
        applyStimulus(1'b0, 1'b1, 1'b1, W'(9'h1AA));
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkSession(SD);

        $display("[TB] reset mid-session");
        clearBoard();
        for (int i = 0; i < SD; i++) sessWords[i] = W'(32 + i);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        feedWords(5, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, W'(9'h0AB));
        applyStimulus(1'b0, 1'b0, 1'b1, W'(9'h0CD));
        checkOutput("abortWrites@5", wrCount[5], 0);
        checkOutput("abortPairs", pairs, 2);
        checkOutput("abortDones", dones, 0);
        clearBoard();
        for (int i = 0; i < SD; i++) sessWords[i] = W'(9'h1F0 + i);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        feedWords(SD, 30);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkSession(SD);

        $display("[TB] full-depth random load");
        sel = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        clearBoard();
        for (int i = 0; i < BD; i++) sessWords[i] = W'($urandom_range(511));
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        feedWords(BD, 25);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkSession(BD);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
